// File: rtl/mem_pkg.sv
// Shared definitions for the M-stage load/store unit.
//   - MEM_OP_* : encodings of the mem_op field driven by the pipeline
//   - EXC_*_DEF: default exception codes for load/store address errors
//   - mem_state_e: FSM states of m_mem_access
//   - op_is_store / addr_misaligned: decode helpers shared by the datapath
package mem_pkg;

    localparam logic [2:0] MEM_OP_LW  = 3'b000;
    localparam logic [2:0] MEM_OP_LH  = 3'b001;
    localparam logic [2:0] MEM_OP_LHU = 3'b010;
    localparam logic [2:0] MEM_OP_LB  = 3'b011;
    localparam logic [2:0] MEM_OP_LBU = 3'b100;
    localparam logic [2:0] MEM_OP_SW  = 3'b101;
    localparam logic [2:0] MEM_OP_SH  = 3'b110;
    localparam logic [2:0] MEM_OP_SB  = 3'b111;

    localparam logic [4:0] EXC_ADEL_DEF = 5'd4;
    localparam logic [4:0] EXC_ADES_DEF = 5'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } mem_state_e;

    function automatic logic op_is_store(input logic [2:0] op);
        return (op == MEM_OP_SW) || (op == MEM_OP_SH) || (op == MEM_OP_SB);
    endfunction

    // Word ops need addr[1:0]==0, halfword ops need addr[0]==0, bytes never fault.
    function automatic logic addr_misaligned(input logic [2:0] op, input logic [1:0] lo);
        logic mis;
        mis = 1'b0;
        case (op)
            MEM_OP_LW, MEM_OP_SW:             mis = (lo != 2'b00);
            MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: mis = lo[0];
            default:                          mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/m_mem_access_if.sv
// Data-bus interface between the M-stage load/store unit and memory.
//   bus_req    : request, held until bus_ack
//   bus_we     : 1 store, 0 load
//   bus_addr   : word-aligned address
//   bus_byteen : byte enables (0000 on loads)
//   bus_wdata  : lane-aligned store data
//   bus_ack    : completion; bus_rdata valid in the same cycle
//   bus_rdata  : read word
// master = load/store unit, slave = memory side.
interface m_mem_access_if;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_byteen;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_byteen,
        output bus_wdata,
        input  bus_ack,
        input  bus_rdata
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_byteen,
        input  bus_wdata,
        output bus_ack,
        output bus_rdata
    );

endinterface

// File: rtl/m_load_ext.sv
// Load lane extraction and extension (purely combinational).
//   op     in  3   load opcode (MEM_OP_LW/LH/LHU/LB/LBU)
//   lane   in  2   addr[1:0] of the access
//   word   in  32  raw bus read word
//   result out 32  selected byte/half, sign- or zero-extended; word for LW
module m_load_ext
    import mem_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  lane,
    input  logic [31:0] word,
    output logic [31:0] result
);

    logic [15:0] shifted;

    always_comb begin
        // Only the low half of the shifted word is ever selected.
        shifted = 16'(word >> {lane, 3'b000});
        result  = word;
        case (op)
            MEM_OP_LB:  result = {{24{shifted[7]}}, shifted[7:0]};
            MEM_OP_LBU: result = {24'd0, shifted[7:0]};
            MEM_OP_LH:  result = {{16{shifted[15]}}, shifted[15:0]};
            MEM_OP_LHU: result = {16'd0, shifted[15:0]};
            default:    result = word;
        endcase
    end

endmodule

// File: rtl/m_mem_access.sv
// M-stage load/store unit: accepts one load/store, drives the data bus,
// extends load data, and reports address errors / bus timeouts.
//   clk, reset          system clock, synchronous active-high reset
//   req_valid           M-stage holds a memory instruction
//   mem_op, addr, wdata opcode, byte address, store source value
//   flush               CP0 flush; aborts whatever is in flight
//   stall               high while an accepted access is still pending
//   done                1-cycle pulse on successful completion
//   rdata               extended load result, held until the next load done
//   exc, exc_code       1-cycle pulse with address-error/timeout code
//   bus                 memory bus (master modport)
//
// state | meaning
// ------+--------------------------------------------------------
// IDLE  | waiting for req_valid
// REQ   | bus_req asserted, waiting for bus_ack or timeout
// DONE  | done pulse, access finished
// ERR   | exc pulse (misaligned address or bus timeout)
module m_mem_access
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [4:0]  EXC_ADEL = EXC_ADEL_DEF,
    parameter logic [4:0]  EXC_ADES = EXC_ADES_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic [2:0]            mem_op,
    input  logic [31:0]           addr,
    input  logic [31:0]           wdata,
    input  logic                  flush,
    output logic                  stall,
    output logic                  done,
    output logic [31:0]           rdata,
    output logic                  exc,
    output logic [4:0]            exc_code,
    m_mem_access_if.master        bus
);

    // Counter holds the number of REQ cycles already spent without ack,
    // so it only needs to reach TIMEOUT-1 before the timeout fires.
    localparam int unsigned CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    mem_state_e        state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [1:0]        lane_q, lane_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              exc_q, exc_d;
    logic [4:0]        exc_code_q, exc_code_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [31:0]       bus_addr_q, bus_addr_d;
    logic [3:0]        bus_byteen_q, bus_byteen_d;
    logic [31:0]       bus_wdata_q, bus_wdata_d;

    logic [3:0]        st_byteen;
    logic [31:0]       st_data;
    logic [31:0]       load_result;

    // Store packing from the incoming request; loads get no enables/data.
    always_comb begin
        st_byteen = 4'b0000;
        st_data   = 32'd0;
        case (mem_op)
            MEM_OP_SW: begin
                st_byteen = 4'b1111;
                st_data   = wdata;
            end
            MEM_OP_SH: begin
                st_byteen = 4'b0011 << addr[1:0];
                st_data   = {2{wdata[15:0]}};
            end
            MEM_OP_SB: begin
                st_byteen = 4'b0001 << addr[1:0];
                st_data   = {4{wdata[7:0]}};
            end
            default: begin
                st_byteen = 4'b0000;
                st_data   = 32'd0;
            end
        endcase
    end

    m_load_ext u_load_ext (
        .op     (op_q),
        .lane   (lane_q),
        .word   (bus.bus_rdata),
        .result (load_result)
    );

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        lane_d       = lane_q;
        cnt_d        = '0;
        done_d       = 1'b0;
        exc_d        = 1'b0;
        exc_code_d   = 5'd0;
        rdata_d      = rdata_q;
        bus_req_d    = 1'b0;
        bus_we_d     = 1'b0;
        bus_addr_d   = 32'd0;
        bus_byteen_d = 4'b0000;
        bus_wdata_d  = 32'd0;

        // Flush wins over everything, including an ack in the same cycle.
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (addr_misaligned(mem_op, addr[1:0])) begin
                            state_d    = ST_ERR;
                            exc_d      = 1'b1;
                            exc_code_d = op_is_store(mem_op) ? EXC_ADES : EXC_ADEL;
                        end else begin
                            state_d      = ST_REQ;
                            op_d         = mem_op;
                            lane_d       = addr[1:0];
                            bus_req_d    = 1'b1;
                            bus_we_d     = op_is_store(mem_op);
                            bus_addr_d   = {addr[31:2], 2'b00};
                            bus_byteen_d = st_byteen;
                            bus_wdata_d  = st_data;
                        end
                    end
                end
                ST_REQ: begin
                    if (bus.bus_ack) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        if (!op_is_store(op_q)) begin
                            rdata_d = load_result;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        state_d    = ST_ERR;
                        exc_d      = 1'b1;
                        exc_code_d = op_is_store(op_q) ? EXC_ADES : EXC_ADEL;
                    end else begin
                        cnt_d        = cnt_q + CNT_W'(1);
                        bus_req_d    = 1'b1;
                        bus_we_d     = bus_we_q;
                        bus_addr_d   = bus_addr_q;
                        bus_byteen_d = bus_byteen_q;
                        bus_wdata_d  = bus_wdata_q;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                ST_ERR:  state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            op_q         <= 3'd0;
            lane_q       <= 2'd0;
            cnt_q        <= '0;
            done_q       <= 1'b0;
            exc_q        <= 1'b0;
            exc_code_q   <= 5'd0;
            rdata_q      <= 32'd0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= 32'd0;
            bus_byteen_q <= 4'b0000;
            bus_wdata_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            lane_q       <= lane_d;
            cnt_q        <= cnt_d;
            done_q       <= done_d;
            exc_q        <= exc_d;
            exc_code_q   <= exc_code_d;
            rdata_q      <= rdata_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_byteen_q <= bus_byteen_d;
            bus_wdata_q  <= bus_wdata_d;
        end
    end

    // Stall rises combinationally on the accepting cycle so the pipeline
    // holds the instruction; it drops in DONE/ERR so the pulse cycle advances.
    assign stall = !reset &&
                   ((state_q == ST_REQ) ||
                    ((state_q == ST_IDLE) && req_valid && !flush));

    assign done           = done_q;
    assign exc            = exc_q;
    assign exc_code       = exc_code_q;
    assign rdata          = rdata_q;
    assign bus.bus_req    = bus_req_q;
    assign bus.bus_we     = bus_we_q;
    assign bus.bus_addr   = bus_addr_q;
    assign bus.bus_byteen = bus_byteen_q;
    assign bus.bus_wdata  = bus_wdata_q;

endmodule
